// File: rtl/prefetch_unit.sv
// prefetch_unit
// -----------------------------------------------------------------------------
// Instruction-fetch front end for the MIPS core. This block owns the PC and
// drives the instruction side of the cache interface. Every request is held
// until the cache answers with ihit. Fetched words, each tagged with its PC,
// go into a DEPTH-entry FIFO so decode can run apart from memory latency.
// A taken branch or jump (redirect) flushes the FIFO and reloads the PC.
// halt stops fetching for good. Only RST leaves the halted state.
//
// Parameters:
//   DATA_W    instruction / PC width
//   DEPTH     FIFO entries (power of two, >= 2)
//   PC_RESET  PC after reset
//   PC_STEP   PC increment per accepted word
//
// Ports:
//   CLK, RST         rising-edge clock, asynchronous active-high reset
//   imemREN          instruction read request (decoded from state only)
//   imemaddr         request address, always the PC register
//   ihit, imemload   cache hit strobe and returned instruction word
//   redirect_valid   branch/jump taken; redirect_pc is the new fetch target
//   halt             stop fetching permanently
//   deq_ready        decode consumes the head entry this cycle
//   inst_valid       FIFO non-empty
//   inst, inst_pc    head instruction and its PC
//   count            FIFO occupancy
//   halted           halted state reached and FIFO fully drained
//
// Optional feature (macro PREFETCH_PERF_EN):
//   stall_cycles     32-bit saturating count of cycles spent waiting on a miss
// -----------------------------------------------------------------------------
module prefetch_unit #(
  parameter int                 DATA_W   = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [DATA_W-1:0]  PC_RESET = '0,
  parameter int                 PC_STEP  = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  output logic                        imemREN,
  output logic [DATA_W-1:0]           imemaddr,
  input  logic                        ihit,
  input  logic [DATA_W-1:0]           imemload,
  input  logic                        redirect_valid,
  input  logic [DATA_W-1:0]           redirect_pc,
  input  logic                        halt,
  input  logic                        deq_ready,
  output logic                        inst_valid,
  output logic [DATA_W-1:0]           inst,
  output logic [DATA_W-1:0]           inst_pc,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  output logic                        halted
`ifdef PREFETCH_PERF_EN
  ,
  output logic [31:0]                 stall_cycles
`endif
);

  localparam int                PTR_W  = $clog2(DEPTH);
  localparam int                CNT_W  = $clog2(DEPTH+1);
  localparam logic [DATA_W-1:0] STEP_W = DATA_W'(PC_STEP);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEPTH-1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FULL   = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [DATA_W-1:0]  pc;
  logic [PTR_W-1:0]   wptr;
  logic [PTR_W-1:0]   rptr;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  mem_inst [DEPTH];
  logic [DATA_W-1:0]  mem_pc   [DEPTH];

  logic               redirect_eff;
  logic               enq;
  logic               deq;

  // Redirects are ignored once halted. The halted state is terminal, and the
  // retained FIFO contents must not be flushed by late branch resolutions.
  // A word is accepted only on a real hit. A redirect or a halt in the same
  // cycle means that word belongs to a path that is no longer wanted, so it
  // is dropped. A flushing redirect also cancels a dequeue in that cycle.
  always_comb begin
    redirect_eff = redirect_valid && (state != ST_HALTED);
    enq          = imemREN && ihit && !redirect_valid && !halt;
    deq          = deq_ready && inst_valid && !redirect_eff;
  end

  // State register. RST takes effect immediately, even mid-miss or mid-drain.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and read-request decode. imemREN depends only on the current
  // state, so the cache sees a request that is stable for the whole cycle.
  // halt wins over everything. A redirect while fetching always returns to
  // RUN, because the flush empties the FIFO. FULL is entered only when an
  // enqueue without a matching dequeue fills the last free slot.
  always_comb begin
    state_next = state;
    imemREN    = 1'b0;
    case (state)
      ST_RUN: begin
        imemREN = 1'b1;
        if (halt) begin
          state_next = ST_HALTED;
        end else if (redirect_valid) begin
          state_next = ST_RUN;
        end else if (enq && !deq && (cnt == CNT_LAST)) begin
          state_next = ST_FULL;
        end
      end
      ST_FULL: begin
        if (halt) begin
          state_next = ST_HALTED;
        end else if (redirect_valid || deq) begin
          state_next = ST_RUN;
        end
      end
      ST_HALTED: begin
        state_next = ST_HALTED;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // PC, FIFO pointers and occupancy. A redirect flushes the FIFO and reloads
  // the PC in one step. Otherwise enqueue and dequeue update their own
  // pointers independently. Both pointers wrap naturally because DEPTH is a
  // power of two. count never passes DEPTH, because no request is issued
  // while FULL.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc   <= PC_RESET;
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (redirect_eff) begin
      pc   <= redirect_pc;
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (enq) begin
        pc   <= pc + STEP_W;
        wptr <= wptr + PTR_W'(1);
      end
      if (deq) begin
        rptr <= rptr + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // FIFO storage. Each entry holds the instruction word and the PC it was
  // fetched from. This is plain storage, so it has no reset. Stale entries
  // are never visible, because inst_valid follows count.
  always_ff @(posedge CLK) begin
    if (enq) begin
      mem_inst[wptr] <= imemload;
      mem_pc[wptr]   <= pc;
    end
  end

  // Output decode. The head entry is read combinationally, so a word fetched
  // in cycle N reaches decode in cycle N+1. halted waits until the retained
  // FIFO has drained, so decode knows every pre-halt word was delivered.
  always_comb begin
    imemaddr   = pc;
    inst_valid = (cnt != '0);
    inst       = mem_inst[rptr];
    inst_pc    = mem_pc[rptr];
    count      = cnt;
    halted     = (state == ST_HALTED) && (cnt == '0);
  end

`ifdef PREFETCH_PERF_EN
  // Miss-stall counter. It counts every cycle a request is outstanding
  // without a hit, and it sticks at all-ones instead of wrapping.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cycles <= '0;
    end else if (imemREN && !ihit && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_prefetch_unit.sv
// tb_prefetch_unit
// -----------------------------------------------------------------------------
// Scoreboard bench for prefetch_unit (DEPTH=4, PC_RESET=0, PC_STEP=4).
// The reference model is a queue of {inst, pc} entries, a model PC and a
// halted flag. Fetch is allowed whenever the model is not halted and the
// queue has room. Each word the model hands to decode is pushed onto an
// expected queue. A separate monitor pops that queue whenever the DUT
// presents a consumed head word, and compares the two.
// The instruction memory is a fixed hash of the address, so every word is
// known from its PC alone.
// -----------------------------------------------------------------------------
module tb_prefetch_unit;

  localparam int          DATA_W   = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] PC_RESET = 32'h0;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        deq_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [2:0]  count;
  logic        halted;
`ifdef PREFETCH_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] stall_base;
`endif

  logic [63:0] mq[$];
  logic [63:0] expq[$];
  logic [31:0] mpc;
  bit          mh;
  bit          cur_redir_eff;
  int          checks = 0;
  int          errors = 0;

  prefetch_unit #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .PC_RESET (PC_RESET),
    .PC_STEP  (4)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .imemREN        (imemREN),
    .imemaddr       (imemaddr),
    .ihit           (ihit),
    .imemload       (imemload),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .deq_ready      (deq_ready),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .count          (count),
    .halted         (halted)
`ifdef PREFETCH_PERF_EN
    ,
    .stall_cycles   (stall_cycles)
`endif
  );

  // Free-running 10 ns clock.
  always #5 CLK = ~CLK;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Compares every output against the model. This runs just after a falling
  // edge, when outputs are settled from the previous rising edge.
  task automatic checkOutput();
    chk("imemREN", 32'(imemREN), 32'(!mh && (mq.size() < DEPTH)));
    chk("imemaddr", imemaddr, mpc);
    chk("count", 32'(count), 32'(mq.size()));
    chk("inst_valid", 32'(inst_valid), 32'(mq.size() > 0));
    chk("halted", 32'(halted), 32'(mh && (mq.size() == 0)));
    if (mq.size() > 0) begin
      chk("head_inst", inst, mq[0][63:32]);
      chk("head_pc", inst_pc, mq[0][31:0]);
    end
  endtask

  task automatic nextCycle();
    @(negedge CLK);
    checkOutput();
  endtask

  // Drives one cycle of inputs and advances the model across the next
  // rising edge.
  task automatic drive(input bit hit, input bit dq, input bit rv,
                       input logic [31:0] rpc, input bit hl);
    bit          ren;
    bit          re;
    bit          en;
    bit          de;
    logic [63:0] e;
    ihit           = hit;
    imemload       = hit ? memword(mpc) : $urandom;
    deq_ready      = dq;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt           = hl;
    ren = !mh && (mq.size() < DEPTH);
    re  = rv && !mh;
    en  = ren && hit && !rv && !hl;
    de  = (mq.size() > 0) && dq && !re;
    if (de) begin
      e = mq.pop_front();
      expq.push_back(e);
    end
    if (re) begin
      mq.delete();
      mpc = rpc;
    end else if (en) begin
      mq.push_back({memword(mpc), mpc});
      mpc = mpc + 32'd4;
    end
    if (hl) mh = 1'b1;
    cur_redir_eff = re;
  endtask

  task automatic applyStimulus(input bit hit, input bit dq, input bit rv,
                               input logic [31:0] rpc, input bit hl);
    nextCycle();
    drive(hit, dq, rv, rpc, hl);
  endtask

  task automatic modelReset();
    mq.delete();
    expq.delete();
    mpc           = PC_RESET;
    mh            = 1'b0;
    cur_redir_eff = 1'b0;
  endtask

  task automatic idleInputs();
    ihit           = 1'b0;
    imemload       = 32'h0;
    deq_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt           = 1'b0;
  endtask

  task automatic doReset();
    @(negedge CLK);
    idleInputs();
    RST = 1'b1;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_addr", imemaddr, PC_RESET);
    modelReset();
    #2;
    RST = 1'b0;
  endtask

  // Pulses reset between edges and checks that state clears without a clock.
  task automatic midReset();
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_addr", imemaddr, PC_RESET);
    chk("midrst_valid", 32'(inst_valid), 32'd0);
    modelReset();
    @(negedge CLK);
    idleInputs();
    #1;
    RST = 1'b0;
  endtask

  // Monitor: whenever decode takes a valid head word, that word must be the
  // next one the model delivered.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge CLK);
      #3;
      if (!RST && inst_valid && deq_ready && !cur_redir_eff) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL deq_unexpected: got pc %h, expected no dequeue", inst_pc);
        end else begin
          e = expq.pop_front();
          chk("deq_inst", inst, e[63:32]);
          chk("deq_pc", inst_pc, e[31:0]);
        end
      end
    end
  end

  initial begin
    bit          hit;
    bit          dq;
    bit          rv;
    bit          hl;
    logic [31:0] rpc;
    RST = 1'b1;
    idleInputs();
    modelReset();

    // Streaming: hit and consume every cycle.
    doReset();
    for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0, 0, 0);

    // Fill with no consumer, then one dequeue re-opens fetch.
    doReset();
    for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, 0, 0);
    nextCycle();
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_ren", 32'(imemREN), 32'd0);
    chk("fill_addr", imemaddr, 32'h10);
    drive(0, 1, 0, 0, 0);
    nextCycle();
    chk("refill_ren", 32'(imemREN), 32'd1);
    drive(0, 0, 0, 0, 0);

    // Redirect with count=3 and a simultaneous hit.
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 32'h400, 0);
    nextCycle();
    chk("redir_count", 32'(count), 32'd0);
    chk("redir_valid", 32'(inst_valid), 32'd0);
    chk("redir_addr", imemaddr, 32'h400);
    drive(0, 0, 0, 0, 0);

    // Miss: five cycles without a hit at 0x20.
    doReset();
    applyStimulus(1, 0, 1, 32'h20, 0);
    nextCycle();
`ifdef PREFETCH_PERF_EN
    stall_base = stall_cycles;
`endif
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0);
    nextCycle();
    chk("miss_addr", imemaddr, 32'h20);
`ifdef PREFETCH_PERF_EN
    chk("miss_stalls", stall_cycles - stall_base, 32'd5);
`endif
    drive(1, 1, 0, 0, 0);

    // Halt with two words buffered, drain them, then a redirect is ignored.
    doReset();
    for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1);
    nextCycle();
    chk("halt_ren", 32'(imemREN), 32'd0);
    chk("halt_count", 32'(count), 32'd2);
    drive(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    nextCycle();
    chk("halt_done", 32'(halted), 32'd1);
    drive(1, 0, 1, 32'h800, 0);
    nextCycle();
    chk("halt_redir_addr", imemaddr, 32'h8);
    chk("halt_redir_halted", 32'(halted), 32'd1);
    drive(0, 0, 0, 0, 0);

    // Halt and redirect together: flush, load the PC, then stay halted.
    doReset();
    for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 32'h100, 1);
    nextCycle();
    chk("hr_count", 32'(count), 32'd0);
    chk("hr_addr", imemaddr, 32'h100);
    chk("hr_halted", 32'(halted), 32'd1);
    drive(0, 0, 0, 0, 0);

    // Reset between clock edges with three words buffered.
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0);
    midReset();
    applyStimulus(1, 1, 0, 0, 0);

    // Randomised traffic, including PC wrap near the top of the address space.
    for (int run = 0; run < 4; run++) begin
      doReset();
      for (int i = 0; i < 400; i++) begin
        hit = ($urandom_range(0, 9) < 7);
        dq  = ($urandom_range(0, 9) < 6);
        rv  = !mh && ($urandom_range(0, 29) == 0);
        rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
        hl  = ($urandom_range(0, 399) == 0);
        applyStimulus(hit, dq, rv, rpc, hl);
      end
    end

    applyStimulus(0, 0, 0, 0, 0);
    nextCycle();
    #4;
    chk("exp_queue_empty", 32'(expq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prefetch_unit.md
# prefetch_unit

Parametrised instruction-fetch front end for the MIPS core: owns the PC, drives the instruction side of the datapath/cache interface with a hold-until-hit handshake, and buffers fetched words in a DEPTH-entry FIFO. The buffer decouples fetch from decode and lets memory latency overlap with execution. It sits between the instruction cache port and the decode stage of the datapath. It supports PC redirects from branch/jump resolution and a terminal halt.

## Interface
- DATA_W, 32: instruction and PC width.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- PC_RESET, 0: PC value after reset.
- PC_STEP, 4: PC increment per accepted word.

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-high reset.
- imemREN  out  1  instruction read request.
- imemaddr  out  DATA_W  request address; always equals the PC register.
- ihit  in  1  cache returns imemload for imemaddr this cycle.
- imemload  in  DATA_W  instruction word.
- redirect_valid  in  1  branch/jump taken.
- redirect_pc  in  DATA_W  new fetch target.
- halt  in  1  stop fetching permanently.
- deq_ready  in  1  decode consumes the head entry this cycle.
- inst_valid  out  1  FIFO non-empty.
- inst  out  DATA_W  head instruction.
- inst_pc  out  DATA_W  PC of head instruction.
- count  out  $clog2(DEPTH+1)  occupancy.
- halted  out  1  in HALTED state with an empty FIFO.

## Operation
- FSM states:
  - RUN: imemREN=1.
  - FULL: imemREN=0; entered when count==DEPTH.
  - HALTED: imemREN=0; terminal.
- FSM transitions:
  - RUN to FULL when an enqueue makes count reach DEPTH.
  - FULL to RUN when a dequeue or redirect lowers count below DEPTH.
  - Any state to HALTED on halt=1; only RST leaves HALTED.
- imemREN is decoded combinationally from the state. Its logic uses no input of the same cycle.
- Enqueue happens when imemREN and ihit are both 1 and there is no redirect or halt that cycle:
  - {imemload, pc} is written at wptr.
  - wptr increments.
  - pc becomes pc+PC_STEP, modulo 2^DATA_W.
- Dequeue happens when deq_ready and inst_valid are both 1: rptr increments. deq_ready with an empty FIFO is ignored.
- Enqueue and dequeue may occur in the same cycle; count is then unchanged.
- Redirect:
  - count, rptr and wptr clear to 0.
  - pc becomes redirect_pc.
  - An ihit in the same cycle is discarded.
  - A dequeue in the same cycle is discarded.
  - State goes to RUN unless halt is also asserted.
- Halt:
  - An ihit in the same cycle is discarded.
  - The FIFO is retained and keeps draining via deq_ready.
  - Halt together with redirect: the redirect still flushes the FIFO and loads the PC, and the state goes to HALTED.
- Pointers are log2(DEPTH) bits wide and wrap naturally. count saturates structurally at DEPTH because imemREN is 0 in FULL.
- inst and inst_pc are read combinationally at rptr. Their values are don't-care when inst_valid=0.

## Timing
- Reset values:
  - state=RUN, pc=PC_RESET, count=0, pointers=0.
  - imemREN=1, imemaddr=PC_RESET.
  - inst_valid=0, halted=0.
- Fetch-to-decode latency: ihit in cycle N makes inst_valid=1 in cycle N+1 when the FIFO was empty. There is no bypass.
- Throughput: one word per cycle with ihit held high and decode consuming every cycle.
- A redirect sampled at edge N puts imemaddr=redirect_pc in cycle N+1 with inst_valid=0.
- A miss holds imemREN and imemaddr stable until ihit. Fetch issues no new address while waiting.
- RST asserted mid-miss or mid-drain returns all state to reset values immediately, without waiting for a clock edge.
- halted rises in the cycle after the dequeue that empties the FIFO in HALTED. It rises in the cycle after halt if the FIFO was already empty.

## Configuration
- PREFETCH_PERF_EN defined:
  - Adds output stall_cycles (32 bits).
  - stall_cycles increments every cycle with imemREN=1 and ihit=0, and saturates at 32'hFFFF_FFFF.
  - RST clears it to 0.
- PREFETCH_PERF_EN undefined: the port and its counter are absent. All other behaviour is identical.

## Test plan
- Streaming:
  - Stimulus: reset with PC_RESET=0, ihit=1 every cycle, deq_ready=1.
  - Response: inst_pc sequence 0,4,8,12 on consecutive cycles starting 1 cycle after reset release; count stays 1.
- Fill:
  - Stimulus: ihit=1 and deq_ready=0 for 6 cycles with DEPTH=4.
  - Response: count reaches 4; imemREN=0 from the 5th cycle; imemaddr holds 0x10; one dequeue restores imemREN=1.
- Redirect:
  - Stimulus: redirect_valid=1 with redirect_pc=0x400 while count=3 and ihit=1.
  - Response: next cycle count=0, inst_valid=0, imemaddr=0x400; the hit word is never seen.
- Miss:
  - Stimulus: ihit low for 5 cycles at pc=0x20.
  - Response: imemaddr stays 0x20; with PREFETCH_PERF_EN, stall_cycles=5.
- Halt:
  - Stimulus: halt with count=2, then deq_ready=1 for 2 cycles.
  - Response: imemREN=0 immediately; 2 words delivered; halted=1 after the second dequeue; later redirects ignored.
- Reset mid-operation:
  - Stimulus: RST pulsed mid-clock with count=3.
  - Response: count=0, imemaddr=PC_RESET before the next edge.
